// File: rtl/regfile_write_arbiter_pkg.sv
// regarb_pkg: shared state type, bus widths and protected-register range for regfile_write_arbiter
package regarb_pkg;
    typedef enum logic {ARB, LOCKED} state_t;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int PROT_LO = 27;
    localparam int PROT_HI = 29;
    function automatic logic [1:0] wrap_inc(input logic [1:0] i, input int n);
        return (int'(i) == n - 1) ? 2'd0 : i + 2'd1;
    endfunction
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: requester handshake plus regfile write port; prot_err exists only with REGARB_PROTECT_EN
interface regfile_write_arbiter_if #(parameter int NREQ = 3);
    import regarb_pkg::*;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0]            req_lock;
    logic [REG_ADDR_W*NREQ-1:0] req_reg;
    logic [REG_DATA_W*NREQ-1:0] req_data;
    logic                       ctrl_writeEnable;
    logic [REG_ADDR_W-1:0]      ctrl_writeReg;
    logic [REG_DATA_W-1:0]      data_writeReg;
    logic [1:0]                 grant_id;
    logic                       locked;
`ifdef REGARB_PROTECT_EN
    logic                       prot_err;
    modport slave (input req_valid, req_lock, req_reg, req_data,
                   output req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, grant_id, locked, prot_err);
    modport master (output req_valid, req_lock, req_reg, req_data,
                    input req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, grant_id, locked, prot_err);
`else
    modport slave (input req_valid, req_lock, req_reg, req_data,
                   output req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, grant_id, locked);
    modport master (output req_valid, req_lock, req_reg, req_data,
                    input req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, grant_id, locked);
`endif
endinterface

// File: rtl/regfile_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin finder, first set valid bit scanning upward from i_ptr with wrap
module rr_pick #(parameter int NREQ = 3) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [1:0]      i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [1:0]      o_idx,
    output logic            o_any
);
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_valid[(int'(i_ptr) + k) % NREQ]) begin
                o_idx = 2'((int'(i_ptr) + k) % NREQ);
                o_any = 1'b1;
            end
        end
        o_gnt = o_any ? ({{(NREQ-1){1'b0}}, 1'b1} << o_idx) : '0;
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the regfile write port with lock/timeout.
// REGARB_PROTECT_EN restricts r27-r29 to requester NREQ-1 and adds prot_err.
module regfile_write_arbiter
    import regarb_pkg::*;
#(
    parameter int NREQ         = 3,
    parameter int LOCK_TIMEOUT = 15
) (
    input logic                    clock,
    input logic                    ctrl_reset_n,
    regfile_write_arbiter_if.slave bus
);
    state_t                r_state, w_state_n;
    logic [1:0]            r_ptr, w_ptr_n, r_owner, w_owner_n, w_idx, w_g, r_gid;
    logic [7:0]            r_cnt, w_cnt_n;
    logic [NREQ-1:0]       w_gnt, w_own, w_ready;
    logic                  w_any, w_acc, w_lock, w_zero, w_prot, r_we;
    logic [REG_ADDR_W-1:0] w_reg, r_wreg;
    logic [REG_DATA_W-1:0] w_data, r_wdata;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_valid(bus.req_valid), .i_ptr(r_ptr), .o_gnt(w_gnt), .o_idx(w_idx), .o_any(w_any)
    );

    assign w_own   = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;
    assign w_g     = (r_state == LOCKED) ? r_owner : w_idx;
    assign w_ready = !ctrl_reset_n ? '0 : (r_state == LOCKED) ? (bus.req_valid & w_own) : w_gnt;
    assign w_acc   = ctrl_reset_n && ((r_state == LOCKED) ? bus.req_valid[r_owner] : w_any);
    assign w_lock  = bus.req_lock[w_g];
    assign w_reg   = bus.req_reg[int'(w_g)*REG_ADDR_W +: REG_ADDR_W];
    assign w_data  = bus.req_data[int'(w_g)*REG_DATA_W +: REG_DATA_W];
    assign w_zero  = (w_reg == '0);
`ifdef REGARB_PROTECT_EN
    logic r_prot;
    assign w_prot = (int'(w_reg) >= PROT_LO) && (int'(w_reg) <= PROT_HI) && (int'(w_g) != NREQ - 1);
    always_ff @(posedge clock) begin
        r_prot <= ctrl_reset_n && w_acc && w_prot;
    end
    assign bus.prot_err = r_prot;
`else
    assign w_prot = 1'b0;
`endif

    assign bus.req_ready        = w_ready;
    assign bus.locked           = (r_state == LOCKED);
    assign bus.ctrl_writeEnable = r_we;
    assign bus.ctrl_writeReg    = r_wreg;
    assign bus.data_writeReg    = r_wdata;
    assign bus.grant_id         = r_gid;

    // Timeout counts only idle owner cycles; any owner beat restarts it.
    always_comb begin
        w_state_n = r_state;
        w_ptr_n   = r_ptr;
        w_owner_n = r_owner;
        w_cnt_n   = r_cnt;
        if (r_state == ARB) begin
            if (w_acc) begin
                w_ptr_n   = wrap_inc(w_g, NREQ);
                w_owner_n = w_g;
                w_cnt_n   = '0;
                w_state_n = w_lock ? LOCKED : ARB;
            end
        end else if (w_acc) begin
            w_cnt_n   = '0;
            w_state_n = w_lock ? LOCKED : ARB;
            w_ptr_n   = w_lock ? r_ptr : wrap_inc(r_owner, NREQ);
        end else if (r_cnt + 8'd1 == 8'(LOCK_TIMEOUT)) begin
            w_cnt_n   = '0;
            w_state_n = ARB;
            w_ptr_n   = wrap_inc(r_owner, NREQ);
        end else begin
            w_cnt_n = r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            r_state <= ARB;
            r_ptr   <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
            r_gid   <= '0;
        end else begin
            r_state <= w_state_n;
            r_ptr   <= w_ptr_n;
            r_owner <= w_owner_n;
            r_cnt   <= w_cnt_n;
            r_we    <= w_acc && !w_zero && !w_prot;
            if (w_acc) begin
                r_wreg  <= w_reg;
                r_wdata <= w_data;
                r_gid   <= w_g;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: table-driven directed vectors plus hand-written protect and timeout sequences
module tb_regfile_write_arbiter;
    logic clock = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    regfile_write_arbiter_if #(.NREQ(3)) bus();
    regfile_write_arbiter #(.NREQ(3), .LOCK_TIMEOUT(15)) dut (
        .clock(clock), .ctrl_reset_n(rst_n), .bus(bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rn;
        logic [2:0]  v;
        logic [2:0]  lk;
        logic [14:0] rg;
        logic [95:0] dt;
        logic [2:0]  rdy;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [1:0]  gid;
        logic        lkd;
    } vec_t;
    vec_t vq[$];

    task automatic add(input logic rn, input logic [2:0] v, input logic [2:0] lk, input logic [14:0] rg,
                       input logic [95:0] dt, input logic [2:0] rdy, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic [1:0] gid, input logic lkd);
        vec_t e;
        e.rn = rn; e.v = v; e.lk = lk; e.rg = rg; e.dt = dt;
        e.rdy = rdy; e.we = we; e.wr = wr; e.wd = wd; e.gid = gid; e.lkd = lkd;
        vq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic [2:0] v, input logic [2:0] lk,
                         input logic [14:0] rg, input logic [95:0] dt);
        rst_n         = rn;
        bus.req_valid = v;
        bus.req_lock  = lk;
        bus.req_reg   = rg;
        bus.req_data  = dt;
    endtask

    initial begin
        int n;
        drive(1'b0, 3'b000, 3'b000, '0, '0);
        add(0, 3'b111, 3'b000, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, 3'b000, 0, 5'd0, 32'h0, 2'd0, 0);
        add(1, 3'b001, 3'b000, {5'd0, 5'd0, 5'd5}, {64'h0, 32'hDEADBEEF}, 3'b001, 1, 5'd5, 32'hDEADBEEF, 2'd0, 0);
        add(1, 3'b000, 3'b000, {5'd0, 5'd0, 5'd5}, {64'h0, 32'hDEADBEEF}, 3'b000, 0, 5'd5, 32'hDEADBEEF, 2'd0, 0);
        add(1, 3'b111, 3'b000, {5'd3, 5'd2, 5'd1}, {32'hAAAA0002, 32'hAAAA0001, 32'hAAAA0000}, 3'b010, 1, 5'd2, 32'hAAAA0001, 2'd1, 0);
        add(1, 3'b111, 3'b000, {5'd3, 5'd2, 5'd1}, {32'hAAAA0002, 32'hAAAA0001, 32'hAAAA0000}, 3'b100, 1, 5'd3, 32'hAAAA0002, 2'd2, 0);
        add(1, 3'b111, 3'b000, {5'd3, 5'd2, 5'd1}, {32'hAAAA0002, 32'hAAAA0001, 32'hAAAA0000}, 3'b001, 1, 5'd1, 32'hAAAA0000, 2'd0, 0);
        add(1, 3'b111, 3'b000, {5'd3, 5'd2, 5'd1}, {32'hAAAA0002, 32'hAAAA0001, 32'hAAAA0000}, 3'b010, 1, 5'd2, 32'hAAAA0001, 2'd1, 0);
        add(1, 3'b111, 3'b100, {5'd27, 5'd2, 5'd1}, {32'hBBBB0000, 32'hAAAA0001, 32'hAAAA0000}, 3'b100, 1, 5'd27, 32'hBBBB0000, 2'd2, 1);
        add(1, 3'b111, 3'b100, {5'd28, 5'd2, 5'd1}, {32'hBBBB0001, 32'hAAAA0001, 32'hAAAA0000}, 3'b100, 1, 5'd28, 32'hBBBB0001, 2'd2, 1);
        add(1, 3'b111, 3'b000, {5'd29, 5'd2, 5'd1}, {32'hBBBB0002, 32'hAAAA0001, 32'hAAAA0000}, 3'b100, 1, 5'd29, 32'hBBBB0002, 2'd2, 0);
        add(1, 3'b111, 3'b000, {5'd29, 5'd2, 5'd1}, {32'hBBBB0002, 32'hAAAA0001, 32'hAAAA0000}, 3'b001, 1, 5'd1, 32'hAAAA0000, 2'd0, 0);
        add(1, 3'b010, 3'b010, {5'd0, 5'd7, 5'd0}, {32'h0, 32'hCCCC0000, 32'h0}, 3'b010, 1, 5'd7, 32'hCCCC0000, 2'd1, 1);
        for (int k = 1; k <= 15; k++)
            add(1, 3'b001, 3'b000, {5'd0, 5'd0, 5'd9}, {64'h0, 32'hCCCC0001}, 3'b000, 0, 5'd7, 32'hCCCC0000, 2'd1, k < 15);
        add(1, 3'b001, 3'b000, {5'd0, 5'd0, 5'd9}, {64'h0, 32'hCCCC0001}, 3'b001, 1, 5'd9, 32'hCCCC0001, 2'd0, 0);
        add(1, 3'b010, 3'b000, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h1234, 32'h0}, 3'b010, 0, 5'd0, 32'h1234, 2'd1, 0);
        add(1, 3'b001, 3'b001, {5'd0, 5'd0, 5'd10}, {64'h0, 32'hEEEE0000}, 3'b001, 1, 5'd10, 32'hEEEE0000, 2'd0, 1);
        add(0, 3'b001, 3'b001, {5'd0, 5'd0, 5'd11}, {64'h0, 32'hEEEE0001}, 3'b000, 0, 5'd0, 32'h0, 2'd0, 0);
        add(1, 3'b111, 3'b000, {5'd14, 5'd13, 5'd12}, {32'hFFFF0002, 32'hFFFF0001, 32'hFFFF0000}, 3'b001, 1, 5'd12, 32'hFFFF0000, 2'd0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clock);
            drive(vq[i].rn, vq[i].v, vq[i].lk, vq[i].rg, vq[i].dt);
            #1;
            chk($sformatf("v%0d.ready", i), 32'(bus.req_ready), 32'(vq[i].rdy));
            @(posedge clock);
            #1;
            chk($sformatf("v%0d.we", i), 32'(bus.ctrl_writeEnable), 32'(vq[i].we));
            chk($sformatf("v%0d.wreg", i), 32'(bus.ctrl_writeReg), 32'(vq[i].wr));
            chk($sformatf("v%0d.wdata", i), bus.data_writeReg, vq[i].wd);
            chk($sformatf("v%0d.gid", i), 32'(bus.grant_id), 32'(vq[i].gid));
            chk($sformatf("v%0d.locked", i), 32'(bus.locked), 32'(vq[i].lkd));
        end

        // requester 0 targets r28; pointer is 1 here so requester 0 is the only candidate
        @(negedge clock);
        drive(1'b1, 3'b001, 3'b000, {5'd0, 5'd0, 5'd28}, {64'h0, 32'h55});
        #1;
        chk("prot.ready", 32'(bus.req_ready), 32'b001);
        @(posedge clock);
        #1;
        chk("prot.wreg", 32'(bus.ctrl_writeReg), 32'd28);
        chk("prot.wdata", bus.data_writeReg, 32'h55);
`ifdef REGARB_PROTECT_EN
        chk("prot.we", 32'(bus.ctrl_writeEnable), 32'd0);
        chk("prot.err", 32'(bus.prot_err), 32'd1);
`else
        chk("prot.we", 32'(bus.ctrl_writeEnable), 32'd1);
`endif
        @(negedge clock);
        drive(1'b1, 3'b000, 3'b000, '0, '0);
        @(posedge clock);
        #1;
        chk("prot.idle_we", 32'(bus.ctrl_writeEnable), 32'd0);
`ifdef REGARB_PROTECT_EN
        chk("prot.err_pulse", 32'(bus.prot_err), 32'd0);
`endif

        // lock by requester 1, then a bounded wait for the forced release
        @(negedge clock);
        drive(1'b1, 3'b010, 3'b010, {5'd0, 5'd3, 5'd0}, {32'h0, 32'h77, 32'h0});
        @(posedge clock);
        #1;
        chk("to.locked", 32'(bus.locked), 32'd1);
        @(negedge clock);
        drive(1'b1, 3'b000, 3'b000, '0, '0);
        n = 0;
        while (bus.locked && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("to.idle_cycles", 32'(n), 32'd15);
        @(negedge clock);
        drive(1'b1, 3'b011, 3'b000, {5'd0, 5'd4, 5'd6}, {32'h0, 32'h88, 32'h66});
        #1;
        chk("to.next_ready", 32'(bus.req_ready), 32'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
